product_accumulator: RTL and testbench

Downstream stage of the shift-and-add multiplier. It consumes each signed product on the multiplier's one-cycle completion pulse and sums a programmed number of products (a dot-product run). Each finished sum is queued in a 2-entry output buffer with a valid/ready handshake. The multiplier has no backpressure, so this block accepts every product presented while a run is active, and flags lost data instead of stalling.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/product_accumulator_sum_fifo.sv | 66 ++++++
 rtl/product_accumulator.sv | 171 +++++++++++++++++
 tb/tb_product_accumulator.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types, default widths and saturation limits for the shift-and-add multiplier datapath.
package mult_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_PROD_WIDTH = 2 * DEF_WIDTH + 1;
  localparam int GUARD_BITS     = 8;
  localparam int DEF_ACC_WIDTH  = DEF_PROD_WIDTH + GUARD_BITS;

  // Wide enough for any accumulator width used with this package.
  localparam int MAX_ACC_W = 128;

  function automatic logic [MAX_ACC_W-1:0] sat_max(input int unsigned w);
    return (MAX_ACC_W'(1) << (w - 1)) - MAX_ACC_W'(1);
  endfunction

  // Low w bits are 1000...0, i.e. the most negative w-bit value.
  function automatic logic [MAX_ACC_W-1:0] sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/product_accumulator_sum_fifo.sv
// Two-entry synchronous FIFO holding finished dot-product sums; asynchronous active-high reset.
module sum_fifo #(
  parameter int DATA_WIDTH = 41
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  // Empty reads as zero so the output is clean after reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of signed multiplier products and queues each total in a 2-entry buffer.
// Define ACC_SATURATE_EN for clamping on accumulator overflow; otherwise the sum wraps.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = 2 * WIDTH + GUARD_BITS + 1,
  parameter int LEN_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   vector_len,
  input  logic [2*WIDTH:0]       product,
  input  logic                   product_valid,
  output logic [ACC_WIDTH-1:0]   sum,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic                   busy,
  output logic                   error
);

  localparam int MSB = ACC_WIDTH - 1;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   error_q, error_d;

  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   acc_add;
  logic [ACC_WIDTH-1:0]   acc_new;
  logic [LEN_WIDTH-1:0]   count_inc;
  logic                   push;
  logic [ACC_WIDTH-1:0]   push_data;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));
  logic sat_q, sat_d;
  logic ovf;
  logic sat_hit;
`endif

  assign prod_ext  = ACC_WIDTH'($signed(product));
  assign count_inc = count_q + LEN_WIDTH'(1);

  always_comb begin
    acc_add = acc_q + prod_ext;
`ifdef ACC_SATURATE_EN
    ovf     = (acc_q[MSB] == prod_ext[MSB]) && (acc_add[MSB] != acc_q[MSB]);
    sat_hit = sat_q || ovf;
    // Once clamped, the run keeps the clamp regardless of later products.
    if (sat_q) begin
      acc_new = acc_q;
    end else if (ovf) begin
      acc_new = acc_q[MSB] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_new = acc_add;
    end
`else
    acc_new = acc_add;
`endif
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    acc_d     = acc_q;
    error_d   = error_q;
    push      = 1'b0;
    push_data = acc_new;
`ifdef ACC_SATURATE_EN
    sat_d     = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (product_valid) begin
          error_d = 1'b1;
        end
        if (start) begin
          if (vector_len == '0) begin
            push      = 1'b1;
            push_data = '0;
          end else begin
            state_d = ACCUM;
            len_d   = vector_len;
            count_d = '0;
            acc_d   = '0;
`ifdef ACC_SATURATE_EN
            sat_d   = 1'b0;
`endif
          end
        end
      end
      ACCUM: begin
        if (product_valid) begin
          acc_d   = acc_new;
          count_d = count_inc;
`ifdef ACC_SATURATE_EN
          sat_d   = sat_hit;
`endif
          if (count_inc == len_q) begin
            push = 1'b1;
            // Back-to-back restart; a zero-length start here would need a second push, so it is ignored.
            if (start && (vector_len != '0)) begin
              len_d   = vector_len;
              count_d = '0;
              acc_d   = '0;
`ifdef ACC_SATURATE_EN
              sat_d   = 1'b0;
`endif
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (push && fifo_full && !pop) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      error_q <= 1'b0;
`ifdef ACC_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      error_q <= error_d;
`ifdef ACC_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign pop       = sum_valid && sum_ready;
  assign sum_valid = !fifo_empty;
  assign busy      = (state_q == ACCUM);
  assign error     = error_q;

  sum_fifo #(
    .DATA_WIDTH (ACC_WIDTH)
  ) u_sum_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (sum),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default-width instance plus a 33-bit accumulator instance.
module tb_product_accumulator;

  localparam int WIDTH  = 16;
  localparam int PW     = 2 * WIDTH + 1;
  localparam int ACCW   = 2 * WIDTH + 9;
  localparam int ACCW_S = 33;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        vector_len;
  logic [PW-1:0]     product;
  logic              product_valid;
  logic              sum_ready;
  logic [ACCW-1:0]   sum;
  logic              sum_valid;
  logic              busy;
  logic              error;
  logic [ACCW_S-1:0] sum_s;
  logic              sum_valid_s;
  logic              busy_s;
  logic              error_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(ACCW), .LEN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .vector_len(vector_len),
    .product(product), .product_valid(product_valid),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .busy(busy), .error(error)
  );

  product_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(ACCW_S), .LEN_WIDTH(8)) dut_s (
    .clk(clk), .reset(reset), .start(start), .vector_len(vector_len),
    .product(product), .product_valid(product_valid),
    .sum(sum_s), .sum_valid(sum_valid_s), .sum_ready(sum_ready),
    .busy(busy_s), .error(error_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One product per cycle for a run already started.
  task automatic feed(input logic [PW-1:0] p);
    product_valid = 1'b1;
    product       = p;
    tick();
    product_valid = 1'b0;
    product       = '0;
  endtask

  task automatic begin_run(input logic [7:0] len);
    start      = 1'b1;
    vector_len = len;
    tick();
    start      = 1'b0;
    vector_len = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vector_len = '0; product = '0;
    product_valid = 1'b0; sum_ready = 1'b1;
    tick();
    check("rst_sum_valid", 64'(sum_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    tick();

    // len=3: 100, -50, 7 -> 57
    begin_run(8'd3);
    check("run3_busy", 64'(busy), 64'd1);
    feed(PW'(100));
    feed(PW'(-50));
    check("run3_mid_valid", 64'(sum_valid), 64'd0);
    feed(PW'(7));
    check("run3_valid", 64'(sum_valid), 64'd1);
    check("run3_sum", 64'(sum), 64'd57);
    check("run3_busy_fall", 64'(busy), 64'd0);
    check("run3_error", 64'(error), 64'd0);
    tick();
    check("run3_popped", 64'(sum_valid), 64'd0);

    // zero-length run
    begin_run(8'd0);
    check("len0_valid", 64'(sum_valid), 64'd1);
    check("len0_sum", 64'(sum), 64'd0);
    check("len0_busy", 64'(busy), 64'd0);
    tick();
    check("len0_popped", 64'(sum_valid), 64'd0);

    // backpressure: third result dropped
    sum_ready = 1'b0;
    begin_run(8'd1); feed(PW'(1));
    begin_run(8'd1); feed(PW'(2));
    check("bp_err_before", 64'(error), 64'd0);
    begin_run(8'd1); feed(PW'(3));
    check("bp_error", 64'(error), 64'd1);
    check("bp_valid", 64'(sum_valid), 64'd1);
    check("bp_head_hold", 64'(sum), 64'd1);
    tick();
    check("bp_head_stable", 64'(sum), 64'd1);
    sum_ready = 1'b1;
    tick();
    check("bp_second", 64'(sum), 64'd2);
    check("bp_second_valid", 64'(sum_valid), 64'd1);
    tick();
    check("bp_drained", 64'(sum_valid), 64'd0);

    // reset mid-run with a buffered result present
    sum_ready = 1'b0;
    begin_run(8'd1); feed(PW'(8));
    begin_run(8'd3); feed(PW'(1));
    reset = 1'b1;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_valid", 64'(sum_valid), 64'd0);
    check("mrst_sum", 64'(sum), 64'd0);
    check("mrst_error", 64'(error), 64'd0);
    tick();
    reset = 1'b0;
    sum_ready = 1'b1;
    tick();
    begin_run(8'd2); feed(PW'(5)); feed(PW'(6));
    check("post_rst_sum", 64'(sum), 64'd11);
    check("post_rst_valid", 64'(sum_valid), 64'd1);
    tick();

    // stray product while IDLE
    feed(PW'(9));
    check("stray_valid", 64'(sum_valid), 64'd0);
    check("stray_error", 64'(error), 64'd1);
    begin_run(8'd1); feed(PW'(4));
    check("after_stray_sum", 64'(sum), 64'd4);
    tick();

    // four products of 2^30: 2^32 in the wide accumulator, overflow in the 33-bit one
    begin_run(8'd4);
    for (int i = 0; i < 4; i++) feed(PW'(33'h0_4000_0000));
    check("wide_sum", 64'(sum), 64'h1_0000_0000);
`ifdef ACC_SATURATE_EN
    check("acc33_sum", 64'(sum_s), 64'h0_FFFF_FFFF);
`else
    check("acc33_sum", 64'(sum_s), 64'h1_0000_0000);
`endif
    check("acc33_valid", 64'(sum_valid_s), 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
